// File: rtl/hex_text_scroller.sv
// Text window engine for a DIGITS-wide 7-segment display: static, looping scroll, scroll-once and blink.
// Blink mode is only built when HEX_TEXT_BLINK_EN is defined; otherwise mode 11 behaves as static.
module hex_text_scroller #(
    parameter int DIGITS   = 6,
    parameter int MAX_LEN  = 32,
    parameter int TICK_DIV = 25_000_000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [$clog2(MAX_LEN)-1:0] wr_addr,
    input  logic [7:0]                 wr_data,
    input  logic [$clog2(MAX_LEN):0]   msg_len,
    input  logic [1:0]                 mode,
    input  logic                       restart,
    output logic                       done,
    output logic [7*DIGITS-1:0]        seg_out
);
    localparam int AW = $clog2(MAX_LEN);
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [AW:0] MAXL = (AW+1)'(MAX_LEN);
    localparam logic [AW:0] DIG  = (AW+1)'(DIGITS);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    localparam logic [1:0] S_STATIC = 2'd0;
    localparam logic [1:0] S_SCROLL = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;
    localparam logic [1:0] S_BLINK  = 2'd3;

    logic [7:0]    text_mem [MAX_LEN];
    logic [AW:0]   ptr;
    logic [AW:0]   len;
    logic [TW-1:0] tick_cnt;
    logic [1:0]    state;
    logic [1:0]    entry;
    logic [1:0]    mode_q;
    logic          tick;
    logic          restart_any;
    logic          blank_all;
    logic [7*DIGITS-1:0] seg_next;

    function automatic logic [6:0] glyph(input logic [7:0] c);
        logic [7:0] u;
        u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
        case (u)
            "0": glyph = 7'b1000000;
            "1": glyph = 7'b1111001;
            "2": glyph = 7'b0100100;
            "3": glyph = 7'b0110000;
            "4": glyph = 7'b0011001;
            "5": glyph = 7'b0010010;
            "6": glyph = 7'b0000010;
            "7": glyph = 7'b1111000;
            "8": glyph = 7'b0000000;
            "9": glyph = 7'b0010000;
            "A": glyph = 7'b0001000;
            "B": glyph = 7'b0000011;
            "C": glyph = 7'b1000110;
            "D": glyph = 7'b0100001;
            "E": glyph = 7'b0000110;
            "F": glyph = 7'b0001110;
            "G": glyph = 7'b1000010;
            "H": glyph = 7'b0001001;
            "I": glyph = 7'b1001111;
            "J": glyph = 7'b1100001;
            "L": glyph = 7'b1000111;
            "N": glyph = 7'b0101011;
            "O": glyph = 7'b1000000;
            "P": glyph = 7'b0001100;
            "R": glyph = 7'b0101111;
            "S": glyph = 7'b0010010;
            "T": glyph = 7'b0000111;
            "U": glyph = 7'b1000001;
            "Y": glyph = 7'b0010001;
            "Z": glyph = 7'b0100100;
            default: glyph = 7'b1111111;
        endcase
    endfunction

    assign len         = (msg_len > MAXL) ? MAXL : msg_len;
    assign tick        = (tick_cnt == TICK_LAST);
    assign restart_any = restart || (mode != mode_q);

    always_comb begin
        entry = S_STATIC;
        if ((mode == 2'b01 || mode == 2'b10) && len > DIG)
            entry = S_SCROLL;
`ifdef HEX_TEXT_BLINK_EN
        if (mode == 2'b11)
            entry = S_BLINK;
`endif
    end

`ifdef HEX_TEXT_BLINK_EN
    logic phase;
    always_ff @(posedge clk) begin
        if (reset)
            phase <= 1'b1;
        else if (restart_any)
            phase <= 1'b1;
        else if (state == S_BLINK && tick)
            phase <= ~phase;
    end
    assign blank_all = (state == S_BLINK) && !phase;
`else
    assign blank_all = 1'b0;
`endif

    // Positions at or past the message end render blank, which also yields the loop gap frame.
    always_comb begin
        int idx;
        logic [AW-1:0] a;
        seg_next = '1;
        idx      = 0;
        a        = '0;
        for (int k = 0; k < DIGITS; k++) begin
            idx = int'(ptr) + k;
            a   = idx[AW-1:0];
            if (!blank_all && idx < int'(len))
                seg_next[7*(DIGITS-k)-1 -: 7] = glyph(text_mem[a]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MAX_LEN; i++)
                text_mem[i] <= 8'h20;
            ptr      <= '0;
            tick_cnt <= '0;
            state    <= S_STATIC;
            mode_q   <= 2'b00;
            done     <= 1'b0;
            seg_out  <= '1;
        end else begin
            mode_q  <= mode;
            seg_out <= seg_next;
            if (wr_en)
                text_mem[wr_addr] <= wr_data;

            if (restart_any) begin
                ptr      <= '0;
                tick_cnt <= '0;
                done     <= 1'b0;
                state    <= entry;
            end else begin
                tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                case (state)
                    S_STATIC: begin
                        ptr  <= '0;
                        done <= 1'b1;
                        if (entry == S_SCROLL) begin
                            state <= S_SCROLL;
                            done  <= 1'b0;
                        end
                    end
                    S_SCROLL: begin
                        done <= 1'b0;
                        if (len <= DIG) begin
                            state <= S_STATIC;
                            ptr   <= '0;
                        end else if (ptr > len) begin
                            ptr <= '0;
                        end else if (tick) begin
                            if (mode == 2'b10) begin
                                if (ptr + 1'b1 >= len - DIG) begin
                                    ptr   <= len - DIG;
                                    state <= S_HOLD;
                                    done  <= 1'b1;
                                end else begin
                                    ptr <= ptr + 1'b1;
                                end
                            end else begin
                                ptr <= (ptr == len) ? '0 : ptr + 1'b1;
                            end
                        end
                    end
                    S_HOLD: begin
                        done <= 1'b1;
                        if (len <= DIG) begin
                            state <= S_STATIC;
                            ptr   <= '0;
                        end else if (ptr > len) begin
                            state <= S_SCROLL;
                            ptr   <= '0;
                            done  <= 1'b0;
                        end
                    end
                    S_BLINK: begin
                        ptr  <= '0;
                        done <= 1'b1;
                    end
                    default: state <= S_STATIC;
                endcase
            end
        end
    end
endmodule
